// File: rtl/audio_i2s_master.sv
// I2S master for a WM8731-class codec: BCLK/LRC generation, square-wave test tone on DACDAT, ADCDAT capture.
// Optional AUDIO_LOOPBACK_EN echoes the captured ADC samples to the DAC instead of the tone.
module audio_i2s_master #(
    parameter int                     BCLK_DIV         = 4,
    parameter int                     FRAME_BCLKS      = 64,
    parameter int                     SAMPLE_BITS      = 16,
    parameter logic [SAMPLE_BITS-1:0] TONE_AMPL        = 16'h1000,
    parameter int                     TONE_HALF_FRAMES = 24
) (
    input  logic                   clk12,
    input  logic                   reset12,
    output logic                   audio_mclk,
    output logic                   audio_bclk,
    output logic                   audio_daclrc,
    output logic                   audio_dacdat,
    output logic                   audio_adclrc,
    input  logic                   audio_adcdat,
    output logic [SAMPLE_BITS-1:0] adc_left,
    output logic [SAMPLE_BITS-1:0] adc_right,
    output logic                   adc_valid
);
    localparam int DIV_W  = $clog2(BCLK_DIV);
    localparam int BIT_W  = $clog2(FRAME_BCLKS);
    localparam int TONE_W = $clog2(TONE_HALF_FRAMES + 1);

    localparam logic [DIV_W-1:0]  DIV_FE    = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_RE    = DIV_W'(BCLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BCLKS - 1);
    localparam logic [BIT_W-1:0]  HALF      = BIT_W'(FRAME_BCLKS / 2);
    localparam logic [BIT_W-1:0]  SLOT_BITS = BIT_W'(SAMPLE_BITS);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF_FRAMES - 1);

    logic [DIV_W-1:0]       div_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [BIT_W-1:0]       bit_next;
    logic [BIT_W-1:0]       pos;
    logic [BIT_W-1:0]       pos_next;
    logic                   fe;
    logic                   re;
    logic                   frame_start;
    logic                   chan_right;
    logic                   chan_right_next;
    logic                   in_slot;
    logic                   in_slot_next;
    logic                   lrc;
    logic [SAMPLE_BITS-1:0] dac_shift_l;
    logic [SAMPLE_BITS-1:0] dac_shift_r;
    logic [SAMPLE_BITS-1:0] adc_shift_l;
    logic [SAMPLE_BITS-1:0] adc_shift_r;
    logic [SAMPLE_BITS-1:0] load_left;
    logic [SAMPLE_BITS-1:0] load_right;
    logic [TONE_W-1:0]      tone_cnt;
    logic [TONE_W-1:0]      tone_cnt_next;
    logic                   tone_pol;
    logic                   tone_pol_next;

    assign audio_mclk   = clk12;
    assign audio_bclk   = div_cnt[DIV_W-1];
    assign audio_daclrc = lrc;
    assign audio_adclrc = lrc;

    assign fe          = (div_cnt == DIV_FE);
    assign re          = (div_cnt == DIV_RE);
    assign frame_start = fe && (bit_cnt == BIT_LAST);
    assign bit_next    = frame_start ? '0 : bit_cnt + BIT_W'(1);

    assign chan_right      = (bit_cnt >= HALF);
    assign chan_right_next = (bit_next >= HALF);
    assign pos             = chan_right ? bit_cnt - HALF : bit_cnt;
    assign pos_next        = chan_right_next ? bit_next - HALF : bit_next;
    assign in_slot         = (pos != '0) && (pos <= SLOT_BITS);
    assign in_slot_next    = (pos_next != '0) && (pos_next <= SLOT_BITS);

    // The reset preload already covers frame 0, so each frame start loads the sample of the
    // post-advance tone state; this gives exactly TONE_HALF_FRAMES frames per half period.
    assign tone_pol_next = tone_pol ^ (tone_cnt == TONE_LAST);
    assign tone_cnt_next = (tone_cnt == TONE_LAST) ? '0 : tone_cnt + TONE_W'(1);

`ifdef AUDIO_LOOPBACK_EN
    assign load_left  = adc_shift_l;
    assign load_right = adc_shift_r;
`else
    localparam logic [SAMPLE_BITS-1:0] TONE_NEG = ~TONE_AMPL + SAMPLE_BITS'(1);
    assign load_left  = tone_pol_next ? TONE_NEG : TONE_AMPL;
    assign load_right = load_left;
`endif

    always_ff @(posedge clk12) begin
        if (reset12) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            lrc          <= 1'b0;
            audio_dacdat <= 1'b0;
            dac_shift_l  <= TONE_AMPL;
            dac_shift_r  <= TONE_AMPL;
            adc_shift_l  <= '0;
            adc_shift_r  <= '0;
            adc_left     <= '0;
            adc_right    <= '0;
            adc_valid    <= 1'b0;
            tone_cnt     <= '0;
            tone_pol     <= 1'b0;
        end else begin
            div_cnt   <= fe ? '0 : div_cnt + DIV_W'(1);
            adc_valid <= 1'b0;

            if (re && in_slot) begin
                if (chan_right)
                    adc_shift_r <= {adc_shift_r[SAMPLE_BITS-2:0], audio_adcdat};
                else
                    adc_shift_l <= {adc_shift_l[SAMPLE_BITS-2:0], audio_adcdat};
            end

            // DACDAT leads with the slot position the counter is about to enter (one-BCLK I2S delay).
            if (fe) begin
                bit_cnt <= bit_next;
                lrc     <= chan_right_next;
                if (frame_start) begin
                    adc_left     <= adc_shift_l;
                    adc_right    <= adc_shift_r;
                    adc_valid    <= 1'b1;
                    dac_shift_l  <= load_left;
                    dac_shift_r  <= load_right;
                    tone_cnt     <= tone_cnt_next;
                    tone_pol     <= tone_pol_next;
                    audio_dacdat <= 1'b0;
                end else if (in_slot_next) begin
                    if (chan_right_next) begin
                        audio_dacdat <= dac_shift_r[SAMPLE_BITS-1];
                        dac_shift_r  <= dac_shift_r << 1;
                    end else begin
                        audio_dacdat <= dac_shift_l[SAMPLE_BITS-1];
                        dac_shift_l  <= dac_shift_l << 1;
                    end
                end else begin
                    audio_dacdat <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_i2s_master.sv
// Directed bench for audio_i2s_master: default instance plus a BCLK_DIV=2 / FRAME_BCLKS=40 instance.
// Honours AUDIO_LOOPBACK_EN when the bundle is built with it.
module tb_audio_i2s_master;
`ifdef AUDIO_LOOPBACK_EN
    localparam logic [15:0] ADC_L = 16'h7FFF;
    localparam logic [15:0] ADC_R = 16'h8001;
`else
    localparam logic [15:0] ADC_L = 16'hA5C3;
    localparam logic [15:0] ADC_R = 16'h1234;
`endif

    logic        clk12 = 1'b0;
    logic        reset12;
    logic        audio_adcdat;
    logic        audio_mclk, audio_bclk, audio_daclrc, audio_dacdat, audio_adclrc, adc_valid;
    logic [15:0] adc_left, adc_right;
    logic        mclk2, bclk2, daclrc2, dacdat2, adclrc2, adc_valid2;
    logic [15:0] adc_left2, adc_right2;

    int          checks;
    int          errors;
    int          cyc;
    logic [15:0] cap_l, cap_r;
    logic [15:0] frame_l [0:63];
    logic [15:0] frame_r [0:63];

    always #5 clk12 = ~clk12;

    audio_i2s_master dut (
        .clk12(clk12), .reset12(reset12), .audio_mclk(audio_mclk), .audio_bclk(audio_bclk),
        .audio_daclrc(audio_daclrc), .audio_dacdat(audio_dacdat), .audio_adclrc(audio_adclrc),
        .audio_adcdat(audio_adcdat), .adc_left(adc_left), .adc_right(adc_right), .adc_valid(adc_valid)
    );

    audio_i2s_master #(.BCLK_DIV(2), .FRAME_BCLKS(40)) dut2 (
        .clk12(clk12), .reset12(reset12), .audio_mclk(mclk2), .audio_bclk(bclk2),
        .audio_daclrc(daclrc2), .audio_dacdat(dacdat2), .audio_adclrc(adclrc2),
        .audio_adcdat(1'b0), .adc_left(adc_left2), .adc_right(adc_right2), .adc_valid(adc_valid2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected DAC word of frame f; adc_w is what the codec drove into that channel.
    function automatic logic [15:0] dac_word(input int f, input logic [15:0] adc_w);
`ifdef AUDIO_LOOPBACK_EN
        return (f == 0) ? 16'h1000 : adc_w;
`else
        return (((f / 24) % 2) == 1) ? 16'hF000 : 16'h1000;
`endif
    endfunction

    // Codec model: MSB one BCLK after the LRC edge, random junk outside the 16-bit window.
    task automatic drive_adc();
        int b, p;
        logic [15:0] w;
        b = (cyc / 4) % 64;
        p = b % 32;
        w = (b >= 32) ? ADC_R : ADC_L;
        if (p >= 1 && p <= 16) audio_adcdat = w[16-p];
        else                   audio_adcdat = 1'($urandom);
    endtask

    task automatic tick();
        @(negedge clk12);
        cyc++;
        drive_adc();
    endtask

    task automatic check_cycle();
        int b, p, f, b2, p2, f2;
        logic [15:0] w;
        logic exp_dat, exp_dat2;
        b = (cyc / 4) % 64;
        p = b % 32;
        f = cyc / 256;
        w = dac_word(f, (b >= 32) ? ADC_R : ADC_L);
        exp_dat = 1'b0;
        if (p >= 1 && p <= 16) exp_dat = w[16-p];
        chk("mclk", audio_mclk, 16'(clk12));
        chk("bclk", audio_bclk, 16'((cyc % 4) >= 2));
        chk("daclrc", audio_daclrc, 16'((cyc % 256) >= 128));
        chk("adclrc", audio_adclrc, 16'((cyc % 256) >= 128));
        chk("dacdat", audio_dacdat, 16'(exp_dat));
        chk("adc_valid", adc_valid, 16'((cyc % 256 == 0) && (cyc >= 256)));
        chk("adc_left", adc_left, (cyc >= 256) ? ADC_L : 16'h0000);
        chk("adc_right", adc_right, (cyc >= 256) ? ADC_R : 16'h0000);

        b2 = (cyc / 2) % 40;
        p2 = b2 % 20;
        f2 = cyc / 80;
        w = dac_word(f2, 16'h0000);
        exp_dat2 = 1'b0;
        if (p2 >= 1 && p2 <= 16) exp_dat2 = w[16-p2];
        chk("bclk2", bclk2, 16'((cyc % 2) == 1));
        chk("lrc2", daclrc2, 16'((cyc % 80) >= 40));
        chk("dacdat2", dacdat2, 16'(exp_dat2));
        chk("adc_valid2", adc_valid2, 16'((cyc % 80 == 0) && (cyc >= 80)));

        if ((cyc % 4) == 2 && p >= 1 && p <= 16) begin
            if (b >= 32) cap_r[16-p] = audio_dacdat;
            else         cap_l[16-p] = audio_dacdat;
        end
        if ((cyc % 256) == 255 && f < 64) begin
            frame_l[f] = cap_l;
            frame_r[f] = cap_r;
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        cap_l        = '0;
        cap_r        = '0;
        reset12      = 1'b1;
        audio_adcdat = 1'b0;
        repeat (3) @(negedge clk12);
        @(posedge clk12);
        #1;
        chk("mclk_high_in_reset", audio_mclk, 16'h0001);
        @(negedge clk12);
        chk("mclk_low_in_reset", audio_mclk, 16'h0000);
        chk("reset_bclk", audio_bclk, 16'h0000);
        chk("reset_lrc", audio_daclrc, 16'h0000);
        chk("reset_dacdat", audio_dacdat, 16'h0000);
        chk("reset_valid", adc_valid, 16'h0000);

        $display("[TB] releasing reset, running 49 frames");
        reset12 = 1'b0;
        cyc     = 0;
        drive_adc();
        for (int i = 0; i < 49 * 256; i++) begin
            check_cycle();
            tick();
        end

`ifdef AUDIO_LOOPBACK_EN
        chk("frame0_left", frame_l[0], 16'h1000);
        chk("frame1_left_echo", frame_l[1], 16'h7FFF);
        chk("frame1_right_echo", frame_r[1], 16'h8001);
        chk("frame2_left_echo", frame_l[2], 16'h7FFF);
`else
        chk("frame0_left", frame_l[0], 16'h1000);
        chk("frame0_right", frame_r[0], 16'h1000);
        chk("frame23_left", frame_l[23], 16'h1000);
        chk("frame24_left", frame_l[24], 16'hF000);
        chk("frame24_right", frame_r[24], 16'hF000);
        chk("frame47_left", frame_l[47], 16'hF000);
        chk("frame48_left", frame_l[48], 16'h1000);
        chk("frame48_right", frame_r[48], 16'h1000);
`endif

        // Reset lands at bit_cnt 20 while BCLK is high.
        while ((cyc % 256) != 82) begin
            check_cycle();
            tick();
        end
        chk("pre_reset_bclk", audio_bclk, 16'h0001);
        reset12 = 1'b1;
        @(negedge clk12);
        chk("midreset_bclk", audio_bclk, 16'h0000);
        chk("midreset_lrc", audio_daclrc, 16'h0000);
        chk("midreset_dacdat", audio_dacdat, 16'h0000);
        chk("midreset_valid", adc_valid, 16'h0000);
        chk("midreset_left", adc_left, 16'h0000);
        chk("midreset_bclk2", bclk2, 16'h0000);

        $display("[TB] released mid-frame reset");
        reset12 = 1'b0;
        cyc     = 0;
        drive_adc();
        for (int i = 0; i < 600; i++) begin
            check_cycle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
